// File: rtl/rd_ctrl_fwft.sv
// Read-side controller for the dual-clock FIFO: binary read pointer, empty/level
// flags, synchronous-read RAM port and a 2-entry first-word-fall-through buffer.
module rd_ctrl_fwft #(
  parameter int P_PTR_MSB  = 4,
  parameter int P_DATA_MSB = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [P_PTR_MSB:0]    i_wr_ptr,
  output logic [P_PTR_MSB:0]    o_rd_ptr,
  output logic                  o_rd_en,
  output logic [P_PTR_MSB:0]    o_rd_addr,
  input  logic [P_DATA_MSB:0]   i_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [P_DATA_MSB:0]   o_data,
  output logic                  o_empty,
  output logic [P_PTR_MSB:0]    o_level
);

  // Handshake: a word transfers on every i_clk edge where o_valid and i_ready are
  // both high; o_data is held stable while o_valid=1 and i_ready=0.

  logic [P_PTR_MSB:0]  r_rd_ptr;
  logic                r_empty;
  logic [P_PTR_MSB:0]  r_level;
  logic                r_inflight;
  logic [1:0]          r_buf_cnt;
  logic                r_valid;
  logic [P_DATA_MSB:0] r_buf0;
  logic [P_DATA_MSB:0] r_buf1;

  logic                w_pop;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic [P_PTR_MSB:0]  w_rd_ptr_next;
  logic [1:0]          w_buf_cnt_next;

  // Occupancy after this edge if no new read is issued: buffered plus in-flight
  // words, minus the one leaving now. Issuing only below 2 keeps the buffer from
  // ever overflowing, whatever i_ready does.
  always_comb begin
    w_pop          = r_valid & i_ready;
    w_occ          = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue        = ~i_rst & (r_rd_ptr != i_wr_ptr) & (w_occ < 3'd2);
    w_rd_ptr_next  = w_issue ? r_rd_ptr + 1'b1 : r_rd_ptr;
    w_buf_cnt_next = w_occ[1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr   <= '0;
      r_empty    <= 1'b1;
      r_level    <= '0;
      r_inflight <= 1'b0;
      r_buf_cnt  <= 2'd0;
      r_valid    <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_rd_ptr   <= w_rd_ptr_next;
      r_empty    <= (w_rd_ptr_next == i_wr_ptr);
      r_level    <= i_wr_ptr - w_rd_ptr_next;
      r_inflight <= w_issue;
      r_buf_cnt  <= w_buf_cnt_next;
      r_valid    <= (w_buf_cnt_next != 2'd0);
      case ({w_pop, r_inflight})
        2'b10: r_buf0 <= r_buf1;
        2'b01: begin
          if (r_buf_cnt == 2'd0) r_buf0 <= i_rd_data;
          else                   r_buf1 <= i_rd_data;
        end
        // Shift first, then the returning word lands behind whatever remains.
        2'b11: begin
          if (r_buf_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_rd_data;
          end else begin
            r_buf0 <= i_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rd_ptr  = r_rd_ptr;
  assign o_rd_en   = w_issue;
  assign o_rd_addr = r_rd_ptr;
  assign o_valid   = r_valid;
  assign o_data    = r_buf0;
  assign o_empty   = r_empty;
  assign o_level   = r_level;

endmodule

// File: tb/tb_rd_ctrl_fwft.sv
// Bench for rd_ctrl_fwft: RAM model, queue-based reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_rd_ctrl_fwft;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [4:0] i_wr_ptr = '0;
  logic [4:0] o_rd_ptr;
  logic       o_rd_en;
  logic [4:0] o_rd_addr;
  logic [7:0] i_rd_data = '0;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_empty;
  logic [4:0] o_level;

  rd_ctrl_fwft #(.P_PTR_MSB(4), .P_DATA_MSB(7)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_ptr(i_wr_ptr), .o_rd_ptr(o_rd_ptr),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_empty(o_empty), .o_level(o_level)
  );

  // clock / RAM
  always #5 i_clk = ~i_clk;

  logic [7:0] mem [0:31];
  always @(posedge i_clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: words owned by the buffer, one optional word in flight
  logic [7:0] exp_q[$];
  logic [4:0] m_ptr = '0;
  logic       m_infl = 1'b0;
  logic [7:0] m_infl_word = '0;
  logic       m_empty = 1'b1;
  logic [4:0] m_level = '0;
  bit         m_armed = 1'b0;
  logic [4:0] addr_log[$];
  logic [7:0] got_q[$];

  always @(negedge i_clk) begin
    bit m_pop, m_issue;
    int occ;
    m_pop   = (exp_q.size() != 0) && i_ready;
    occ     = exp_q.size() + int'(m_infl) - int'(m_pop);
    m_issue = !i_rst && (m_ptr != i_wr_ptr) && (occ < 2);
    if (m_armed) begin
      chk("valid", o_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("data", o_data, exp_q[0]);
      chk("rd_ptr", o_rd_ptr, m_ptr);
      chk("rd_addr", o_rd_addr, m_ptr);
      chk("empty", o_empty, m_empty);
      chk("level", o_level, m_level);
      chk("rd_en", o_rd_en, m_issue);
      if (o_rd_en) addr_log.push_back(o_rd_addr);
      if (o_valid && i_ready) got_q.push_back(o_data);
    end
    if (i_rst) begin
      exp_q.delete();
      m_ptr = '0; m_infl = 1'b0; m_empty = 1'b1; m_level = '0;
      m_armed = 1'b1;
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_infl) exp_q.push_back(m_infl_word);
      m_infl = m_issue;
      if (m_issue) begin
        m_infl_word = mem[m_ptr];
        m_ptr = m_ptr + 5'd1;
      end
      m_empty = (m_ptr == i_wr_ptr);
      m_level = i_wr_ptr - m_ptr;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic rst_seq();
    i_rst = 1'b1; i_wr_ptr = '0; i_ready = 1'b0;
    step(2);
    i_rst = 1'b0;
    step(1);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 8'(k);

    // reset with a nonzero write pointer
    i_rst = 1'b1; i_wr_ptr = 5'd5;
    step(2);
    @(negedge i_clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_ptr", o_rd_ptr, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_level", o_level, 0);
    chk("rst_data", o_data, 0);
    step(1);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rel_rd_en", o_rd_en, 1);
    chk("rel_addr", o_rd_addr, 0);

    // single word
    mem[0] = 8'hA5;
    rst_seq();
    i_wr_ptr = 5'd1; i_ready = 1'b1;
    @(negedge i_clk);
    chk("sw_rd_en_c0", o_rd_en, 1);
    chk("sw_addr_c0", o_rd_addr, 0);
    step(2);
    @(negedge i_clk);
    chk("sw_valid_c2", o_valid, 1);
    chk("sw_data_c2", o_data, 8'hA5);
    step(1);
    @(negedge i_clk);
    chk("sw_valid_c3", o_valid, 0);
    chk("sw_ptr_c3", o_rd_ptr, 1);
    chk("sw_empty_c3", o_empty, 1);
    mem[0] = 8'h00;

    // streaming, no gaps
    rst_seq();
    i_wr_ptr = 5'd10; i_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge i_clk);
      if (c >= 2 && c <= 11) begin
        chk("st_valid", o_valid, 1);
        chk("st_data", o_data, c - 2);
      end
      if (c == 12) chk("st_valid_end", o_valid, 0);
      if (c >= 1 && c <= 10) chk("st_level", o_level, 10 - c);
      step(1);
    end

    // backpressure, then toggling ready
    rst_seq();
    addr_log.delete();
    i_wr_ptr = 5'd8; i_ready = 1'b0;
    step(5);
    @(negedge i_clk);
    chk("bp_reads", addr_log.size(), 2);
    chk("bp_ptr", o_rd_ptr, 2);
    chk("bp_valid", o_valid, 1);
    chk("bp_data", o_data, 0);
    step(1);
    got_q.delete();
    for (int c = 0; c < 40; c++) begin
      i_ready = c[0] ? 1'b0 : 1'b1;
      step(1);
    end
    i_ready = 1'b0;
    chk("bp_count", got_q.size(), 8);
    for (int k = 0; k < got_q.size() && k < 8; k++) chk("bp_order", got_q[k], k);

    // pointer wrap
    rst_seq();
    i_ready = 1'b1; i_wr_ptr = 5'd30;
    step(36);
    @(negedge i_clk);
    chk("wr_pre_ptr", o_rd_ptr, 30);
    chk("wr_pre_empty", o_empty, 1);
    step(1);
    addr_log.delete();
    i_wr_ptr = 5'd2;
    step(8);
    @(negedge i_clk);
    chk("wr_reads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wr_a0", addr_log[0], 30);
      chk("wr_a1", addr_log[1], 31);
      chk("wr_a2", addr_log[2], 0);
      chk("wr_a3", addr_log[3], 1);
    end
    chk("wr_ptr_end", o_rd_ptr, 2);
    chk("wr_empty_end", o_empty, 1);

    // reset mid-stream with a full buffer
    rst_seq();
    i_ready = 1'b0; i_wr_ptr = 5'd6;
    step(3);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("mr_rd_en_rst", o_rd_en, 0);
    step(1);
    i_rst = 1'b0;
    addr_log.delete();
    got_q.delete();
    @(negedge i_clk);
    chk("mr_valid", o_valid, 0);
    chk("mr_ptr", o_rd_ptr, 0);
    i_ready = 1'b1;
    step(12);
    chk("mr_first_addr", (addr_log.size() != 0) ? addr_log[0] : 5'h1f, 0);
    chk("mr_count", got_q.size(), 6);
    for (int k = 0; k < got_q.size() && k < 6; k++) chk("mr_order", got_q[k], k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
